// File: rtl/mmio_fabric_pkg.sv
// Shared types, region map and decode helper for the MMIO bus fabric.
// Region tables are 32 bits wide; narrower address buses are zero-extended before matching.
package mmio_fabric_pkg;

    localparam int N_SLV_MAX = 8;
    localparam int SLOT_W    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } fabric_state_t;

    localparam logic [31:0] REGION_BASE [N_SLV_MAX] = '{
        32'h0000_0000, 32'h0000_0400, 32'h0000_0800, 32'h0000_0900,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF
    };

    localparam logic [31:0] REGION_MASK [N_SLV_MAX] = '{
        32'hFFFF_FC00, 32'hFFFF_FF80, 32'hFFFF_FF00, 32'hFFFF_FF00,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF
    };

    localparam logic [2:0] REGION_WAIT [N_SLV_MAX] = '{
        3'd0, 3'd1, 3'd3, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0
    };

    function automatic logic region_match(input logic [31:0] addr, input int idx);
        return (addr & REGION_MASK[idx]) == REGION_BASE[idx];
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational base/mask region decode with lowest-index priority.
module mmio_addr_decode
    import mmio_fabric_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int N_SLV  = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SLOT_W-1:0] slot,
    output logic [2:0]        wait_cycles
);

    logic [31:0] addr_ext;

    assign addr_ext = 32'(addr);

    // Scan from the top slot down so the lowest matching index is the last to assign
    always_comb begin
        hit         = 1'b0;
        slot        = {SLOT_W{1'b0}};
        wait_cycles = 3'd0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (region_match(addr_ext, i)) begin
                hit         = 1'b1;
                slot        = SLOT_W'(i);
                wait_cycles = REGION_WAIT[i];
            end else begin
                hit         = hit;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Registered request/response MMIO fabric: decode, per-region wait states, error on miss.
// Optional RESP counters (stat_acc, stat_err) are enabled by defining MMIO_FABRIC_STATS_EN.
module mmio_bus_fabric
    import mmio_fabric_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_SLV  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic [N_SLV-1:0]        slv_en,
    output logic                    slv_we,
    output logic [ADDR_W-1:0]       slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata
`ifdef MMIO_FABRIC_STATS_EN
    ,
    output logic [15:0]             stat_acc,
    output logic [15:0]             stat_err
`endif
);

    fabric_state_t     state_q, state_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              dec_hit;
    logic [SLOT_W-1:0] dec_slot;
    logic [2:0]        dec_wait;
    logic [DATA_W-1:0] rd_sel;

    mmio_addr_decode #(
        .ADDR_W (ADDR_W),
        .N_SLV  (N_SLV)
    ) u_decode (
        .addr        (req_addr),
        .hit         (dec_hit),
        .slot        (dec_slot),
        .wait_cycles (dec_wait)
    );

    // Read-data mux selecting the active slot's lane
    always_comb begin
        rd_sel = {DATA_W{1'b0}};
        for (int i = 0; i < N_SLV; i++) begin
            rd_sel = (slot_q == SLOT_W'(i)) ? slv_rdata[i*DATA_W +: DATA_W] : rd_sel;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = {DATA_W{1'b0}};
                    slot_d  = dec_slot;
                    cnt_d   = dec_wait;
                    if (dec_hit) begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    rdata_d = we_q ? {DATA_W{1'b0}} : rd_sel;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            slot_q  <= {SLOT_W{1'b0}};
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave-side strobes are pure decodes of registered state
    always_comb begin
        slv_en = {N_SLV{1'b0}};
        for (int i = 0; i < N_SLV; i++) begin
            slv_en[i] = (state_q == ACCESS) && (slot_q == SLOT_W'(i));
        end
    end

    assign slv_we    = (state_q == ACCESS) && (cnt_q == 3'd0) && we_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (state_q == RESP) ? rdata_q : {DATA_W{1'b0}};
    assign rsp_err   = (state_q == RESP) && err_q;

`ifdef MMIO_FABRIC_STATS_EN
    logic [15:0] stat_acc_q, stat_acc_d;
    logic [15:0] stat_err_q, stat_err_d;

    // Saturating response counters
    always_comb begin
        stat_acc_d = stat_acc_q;
        stat_err_d = stat_err_q;
        if (state_q == RESP) begin
            stat_acc_d = (stat_acc_q == 16'hFFFF) ? stat_acc_q : stat_acc_q + 16'd1;
            stat_err_d = (err_q && (stat_err_q != 16'hFFFF)) ? stat_err_q + 16'd1 : stat_err_q;
        end else begin
            stat_acc_d = stat_acc_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc_q <= 16'd0;
            stat_err_q <= 16'd0;
        end else begin
            stat_acc_q <= stat_acc_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_acc = stat_acc_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed, table-driven bench for mmio_bus_fabric with hand-computed expectations.
module tb_mmio_bus_fabric;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   slv_en;
    logic         slv_we;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [127:0] slv_rdata;
`ifdef MMIO_FABRIC_STATS_EN
    logic [15:0]  stat_acc;
    logic [15:0]  stat_err;
`endif

    int n_vec;
    int n_fail;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  en;
        int          en_cyc;
        int          we_cyc;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [11];

    mmio_bus_fabric #(
        .ADDR_W (32),
        .DATA_W (32),
        .N_SLV  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .slv_en    (slv_en),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata)
`ifdef MMIO_FABRIC_STATS_EN
        ,
        .stat_acc  (stat_acc),
        .stat_err  (stat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int v);
        int          en_cnt;
        int          we_c;
        int          rsp_c;
        logic        bad_en;
        logic [31:0] rd;
        logic        er;
        logic [31:0] sa;
        logic [31:0] sw;
        en_cnt = 0; we_c = 0; rsp_c = 0; bad_en = 1'b0;
        rd = 32'h0; er = 1'b0; sa = 32'h0; sw = 32'h0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = vecs[v].we;
        req_addr  = vecs[v].addr;
        req_wdata = vecs[v].wdata;
        check($sformatf("v%0d_ready", v), {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        for (int c = 1; c <= 20 && rsp_c == 0; c++) begin
            @(negedge clk);
            if (slv_en != 4'b0000) begin
                en_cnt++;
                if (slv_en !== vecs[v].en) bad_en = 1'b1;
            end
            if (slv_we) we_c = (we_c == 0) ? c : 99;
            if (rsp_valid) begin
                rsp_c = c;
                rd = rsp_rdata;
                er = rsp_err;
                sa = slv_addr;
                sw = slv_wdata;
            end
        end
        check($sformatf("v%0d_en_onehot", v), {31'd0, bad_en}, 32'd0);
        check($sformatf("v%0d_en_cycles", v), en_cnt, vecs[v].en_cyc);
        check($sformatf("v%0d_we_cycle", v), we_c, vecs[v].we_cyc);
        check($sformatf("v%0d_rsp_latency", v), rsp_c, vecs[v].lat);
        check($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
        check($sformatf("v%0d_err", v), {31'd0, er}, {31'd0, vecs[v].err});
        check($sformatf("v%0d_slv_addr", v), sa, vecs[v].addr);
        if (vecs[v].we) check($sformatf("v%0d_slv_wdata", v), sw, vecs[v].wdata);
        @(negedge clk);
        check($sformatf("v%0d_rsp_one_cycle", v), {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        slv_rdata = {32'hC3C3_0003, 32'hA5A5_0002, 32'h4845_4C4C, 32'hDEAD_BEEF};
        //            we    addr          wdata         en       enc we lat rdata         err
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,        4'b0001, 1, 0, 2, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0404, 32'h0,        4'b0010, 2, 0, 3, 32'h4845_4C4C, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0910, 32'h1234_5678, 4'b1000, 8, 8, 9, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h0000_2000, 32'h0,        4'b0000, 0, 0, 1, 32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'h0000_087C, 32'h0,        4'b0100, 4, 0, 5, 32'hA5A5_0002, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'b0001, 1, 1, 2, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0480, 32'h0,        4'b0000, 0, 0, 1, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_047F, 32'h0,        4'b0010, 2, 0, 3, 32'h4845_4C4C, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_09FF, 32'h0,        4'b1000, 8, 0, 9, 32'hC3C3_0003, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0A00, 32'h5555_AAAA, 4'b0000, 0, 0, 1, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0000_0400, 32'h0,        4'b0010, 2, 0, 3, 32'h4845_4C4C, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_slv_en", {28'd0, slv_en}, 32'd0);
        check("rst_slv_we", {31'd0, slv_we}, 32'd0);
        check("rst_slv_addr", slv_addr, 32'd0);
        check("rst_slv_wdata", slv_wdata, 32'd0);

        for (int v = 0; v < 11; v++) run_vec(v);
`ifdef MMIO_FABRIC_STATS_EN
        check("stat_acc_total", {16'd0, stat_acc}, 32'd11);
        check("stat_err_total", {16'd0, stat_err}, 32'd3);
`endif

        // Reset in the 2nd ACCESS cycle of a slot3 write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0910; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        check("mid_rst_access1_en", {28'd0, slv_en}, 32'h8);
        @(negedge clk);
        check("mid_rst_access2_en", {28'd0, slv_en}, 32'h8);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_slv_en", {28'd0, slv_en}, 32'd0);
        check("mid_rst_slv_we", {31'd0, slv_we}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_slv_addr", slv_addr, 32'd0);
        check("mid_rst_slv_wdata", slv_wdata, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (rsp_valid || slv_en != 4'b0000 || slv_we) seen++;
            end
            check("mid_rst_no_activity", seen, 32'd0);
        end
`ifdef MMIO_FABRIC_STATS_EN
        check("mid_rst_stat_acc", {16'd0, stat_acc}, 32'd0);
`endif

        // Back-to-back reads with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
        check("b2b_ready_k", {31'd0, req_ready}, 32'd1);
        begin
            logic [3:0] exp_ready [5];
            logic [3:0] exp_rsp [5];
            logic [3:0] exp_en [5];
            exp_ready = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
            exp_rsp   = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd1};
            exp_en    = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c == 4) req_valid = 1'b0;
                check($sformatf("b2b_c%0d_ready", c), {31'd0, req_ready}, {28'd0, exp_ready[c-1]});
                check($sformatf("b2b_c%0d_rsp", c), {31'd0, rsp_valid}, {28'd0, exp_rsp[c-1]});
                check($sformatf("b2b_c%0d_en", c), {28'd0, slv_en}, {28'd0, exp_en[c-1]});
                if (exp_rsp[c-1] == 4'd1) check($sformatf("b2b_c%0d_rdata", c), rsp_rdata, 32'hDEAD_BEEF);
            end
        end
        @(negedge clk);
        check("b2b_end_ready", {31'd0, req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
